// File: rtl/dst_e_pkg.sv
// Shared CPU decode constants: opcodes, function codes and register indices
// used by the destination-register selector.
package dst_e_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [4:0] reg_idx_t;

  localparam opcode_t IROP   = 6'b000000;
  localparam opcode_t IJ     = 6'b000010;
  localparam opcode_t IJAL   = 6'b000011;
  localparam opcode_t IBEQ   = 6'b000100;
  localparam opcode_t IBNE   = 6'b000101;
  localparam opcode_t IADDI  = 6'b001000;
  localparam opcode_t IADDIU = 6'b001001;
  localparam opcode_t ISLTI  = 6'b001010;
  localparam opcode_t IANDI  = 6'b001100;
  localparam opcode_t IORI   = 6'b001101;
  localparam opcode_t ILUI   = 6'b001111;
  localparam opcode_t ILW    = 6'b100011;
  localparam opcode_t ISW    = 6'b101011;

  localparam opcode_t FJR    = 6'b001000;

  localparam reg_idx_t RNONE = 5'd0;
  localparam reg_idx_t RLINK = 5'd31;

endpackage

// File: rtl/dst_e_if.sv
// Decode-stage fields, E-stage control and destination outputs of dst_e.
interface dst_e_if;
  logic [5:0] D_op;
  logic [5:0] D_funct;
  logic [4:0] D_rt;
  logic [4:0] D_rd;
  logic       E_stall;
  logic       E_bubble;
  logic [4:0] d_dstE;
  logic [4:0] E_dstE;

  modport master (
    output D_op, D_funct, D_rt, D_rd, E_stall, E_bubble,
    input  d_dstE, E_dstE
  );

  modport slave (
    input  D_op, D_funct, D_rt, D_rd, E_stall, E_bubble,
    output d_dstE, E_dstE
  );
endinterface

// File: rtl/dst_e_dec.sv
// Combinational opcode/funct decoder producing the write-back GPR index.
// DST_E_JAL_EN: when defined, JAL writes the link register r31.
module dst_e_dec
  import dst_e_pkg::*;
(
  input  opcode_t  op_i,
  input  logic [5:0] funct_i,
  input  reg_idx_t rt_i,
  input  reg_idx_t rd_i,
  output reg_idx_t dst_o
);

  always_comb begin
    dst_o = RNONE;
    case (op_i)
      IROP:    dst_o = (funct_i == FJR) ? RNONE : rd_i;
      IADDI, IADDIU, ISLTI, IANDI, IORI, ILUI, ILW:
               dst_o = rt_i;
`ifdef DST_E_JAL_EN
      IJAL:    dst_o = RLINK;
`else
      IJAL:    dst_o = RNONE;
`endif
      default: dst_o = RNONE;
    endcase
  end

endmodule

// File: rtl/dst_e.sv
// Destination-register selector plus the D->E pipeline register holding it.
// DST_E_JAL_EN (see dst_e_dec) selects r31 for JAL.
module dst_e
  import dst_e_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  dst_e_if.slave bus_io
);

  reg_idx_t d_dst;
  reg_idx_t e_dst_q;
  reg_idx_t e_dst_d;

  dst_e_dec u_dec (
    .op_i    (bus_io.D_op),
    .funct_i (bus_io.D_funct),
    .rt_i    (bus_io.D_rt),
    .rd_i    (bus_io.D_rd),
    .dst_o   (d_dst)
  );

  // Stall outranks bubble so a held instruction is never squashed.
  always_comb begin
    e_dst_d = e_dst_q;
    if (!bus_io.E_stall) begin
      e_dst_d = bus_io.E_bubble ? RNONE : d_dst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) e_dst_q <= RNONE;
    else     e_dst_q <= e_dst_d;
  end

  assign bus_io.d_dstE = d_dst;
  assign bus_io.E_dstE = e_dst_q;

endmodule

// File: tb/tb_dst_e.sv
// Self-checking bench for dst_e: directed cases plus randomized traffic
// against a behavioural model of the destination rules.
module tb_dst_e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dst_e_if bus();

  dst_e dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_e = 5'd0;

`ifdef DST_E_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Destination rules: list of opcodes that write rt, R-type writes rd unless JR.
  function automatic logic [4:0] ref_dst(input logic [5:0] op, input logic [5:0] funct,
                                         input logic [4:0] rt, input logic [4:0] rd);
    logic [5:0] rt_ops [7];
    rt_ops = '{6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd15, 6'd35};
    if (op == 6'd0) return (funct == 6'd8) ? 5'd0 : rd;
    for (int k = 0; k < 7; k++) if (op == rt_ops[k]) return rt;
    if (op == 6'd3) return JAL_EN ? 5'd31 : 5'd0;
    return 5'd0;
  endfunction

  // One transaction: drive at negedge, check comb output, clock, check register.
  task automatic step(input string tag, input logic [5:0] op, input logic [5:0] funct,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic stall, input logic bubble);
    logic [4:0] d_exp;
    bus.D_op = op; bus.D_funct = funct; bus.D_rt = rt; bus.D_rd = rd;
    bus.E_stall = stall; bus.E_bubble = bubble;
    d_exp = ref_dst(op, funct, rt, rd);
    #1;
    check_val({tag, "_d"}, bus.d_dstE, d_exp);
    @(posedge clk);
    if (rst) exp_e = 5'd0;
    else if (!stall) exp_e = bubble ? 5'd0 : d_exp;
    #1;
    check_val({tag, "_e"}, bus.E_dstE, exp_e);
    $display("txn %s op=%b funct=%b rt=%0d rd=%0d st=%0b bb=%0b d=%0d E=%0d",
             tag, op, funct, rt, rd, stall, bubble, bus.d_dstE, bus.E_dstE);
    @(negedge clk);
  endtask

  logic [5:0] op_tab [14];

  initial begin
    op_tab = '{6'd0, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd15, 6'd35,
               6'd43, 6'd4, 6'd5, 6'd2, 6'd3, 6'd63};
    bus.D_op = 6'd0; bus.D_funct = 6'd0; bus.D_rt = 5'd0; bus.D_rd = 5'd0;
    bus.E_stall = 1'b0; bus.E_bubble = 1'b0;
    rst = 1'b1;
    #1;
    check_val("reset_e", bus.E_dstE, 5'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed selection cases
    step("rtype",   6'b000000, 6'b100000, 5'd8,  5'd9,  1'b0, 1'b0);
    step("addi",    6'b001000, 6'd0,      5'd10, 5'd11, 1'b0, 1'b0);
    step("andi_r0", 6'b001100, 6'd0,      5'd0,  5'd7,  1'b0, 1'b0);
    step("lw",      6'b100011, 6'd0,      5'd3,  5'd4,  1'b0, 1'b0);
    step("ori",     6'b001101, 6'd0,      5'd1,  5'd3,  1'b0, 1'b0);
    step("sw",      6'b101011, 6'd0,      5'd1,  5'd0,  1'b0, 1'b0);
    step("beq",     6'b000100, 6'd0,      5'd6,  5'd7,  1'b0, 1'b0);
    step("jr",      6'b000000, 6'b001000, 5'd4,  5'd5,  1'b0, 1'b0);
    step("undef",   6'b111111, 6'd0,      5'd12, 5'd13, 1'b0, 1'b0);
    step("jal",     6'b000011, 6'd0,      5'd2,  5'd3,  1'b0, 1'b0);

    // Pipeline control
    step("load9",   6'b000000, 6'b100000, 5'd8,  5'd9,  1'b0, 1'b0);
    step("stall",   6'b001000, 6'd0,      5'd10, 5'd11, 1'b1, 1'b0);
    step("bubble",  6'b001000, 6'd0,      5'd10, 5'd11, 1'b0, 1'b1);
    step("load9b",  6'b000000, 6'b100000, 5'd8,  5'd9,  1'b0, 1'b0);
    step("both",    6'b001000, 6'd0,      5'd10, 5'd11, 1'b1, 1'b1);

    // Asynchronous reset between edges
    rst = 1'b1;
    #1;
    check_val("async_rst", bus.E_dstE, 5'd0);
    exp_e = 5'd0;
    step("in_rst",  6'b000000, 6'b100000, 5'd8,  5'd9,  1'b0, 1'b0);
    rst = 1'b0;
    step("post_rst", 6'b000000, 6'b100000, 5'd8, 5'd9,  1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, funct;
      logic [4:0] rt, rd;
      logic st, bb;
      op    = ($urandom_range(3) == 0) ? 6'($urandom) : op_tab[$urandom_range(13)];
      funct = ($urandom_range(3) == 0) ? 6'b001000 : 6'($urandom);
      rt    = 5'($urandom);
      rd    = 5'($urandom);
      st    = ($urandom_range(4) == 0);
      bb    = ($urandom_range(4) == 0);
      step($sformatf("rnd%0d", n), op, funct, rt, rd, st, bb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
